// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: one multiply-accumulate per cycle over
// TAPS taps per accepted sample, with a sample history ring buffer and a
// run-time-writable coefficient bank. Output is saturated to OW bits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a sample; coefficient writes accepted here only
// MAC   | accumulating coef[k] * x[newest-k], one tap per cycle
// DONE  | result presented on m_data, held until the consumer takes it
module fir_mac_sequencer #(
    parameter int TAPS = 4,
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int OW   = 16,
    parameter int AW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    input  logic                 coef_wr_en,
    input  logic [AW-1:0]        coef_wr_addr,
    input  logic signed [CW-1:0] coef_wr_data,
    output logic                 cfg_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [OW-1:0] m_data,
    output logic                 busy
);

    localparam int ACCW = DW + CW + AW;
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_W   = (AW + 1)'(TAPS);
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW - OW + 1){1'b1}}, {(OW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0]      x_mem [TAPS];
    logic signed [CW-1:0]      coef  [TAPS];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             k;
    logic [AW-1:0]             rd_idx;
    logic signed [ACCW-1:0]    acc;
    logic signed [DW+CW-1:0]   prod;
    logic                      accept;
    logic                      fire;
    logic                      coef_we;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode and handshake outputs, all derived from the current state.
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        cfg_ready = 1'b0;
        m_valid   = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                s_ready   = 1'b1;
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (s_valid) state_d = MAC;
            end
            MAC: begin
                if (k == LAST_TAP) state_d = DONE;
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept  = s_valid & s_ready;
    assign fire    = m_valid & m_ready;
    // Out-of-range addresses (non-power-of-2 TAPS) are ignored.
    assign coef_we = coef_wr_en & cfg_ready & ({1'b0, coef_wr_addr} < TAPS_W);

    // History read index (wr_ptr - k) mod TAPS, wrapping explicitly so any TAPS works.
    always_comb begin
        if (k > wr_ptr) rd_idx = AW'({1'b0, wr_ptr} + TAPS_W - {1'b0, k});
        else            rd_idx = wr_ptr - k;
    end

    // Full-precision signed product of the current tap.
    assign prod = (DW + CW)'(coef[k]) * (DW + CW)'(x_mem[rd_idx]);

    // Accumulator, tap counter and ring write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            k      <= '0;
            wr_ptr <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    k   <= (k == LAST_TAP) ? '0 : k + AW'(1);
                end
                DONE: begin
                    if (fire) wr_ptr <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    // Sample history and coefficient bank; coefficients default to 1 (moving sum).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                x_mem[i] <= '0;
                coef[i]  <= CW'(1);
            end
        end else begin
            if (accept)  x_mem[wr_ptr]     <= s_data;
            if (coef_we) coef[coef_wr_addr] <= coef_wr_data;
        end
    end

    // Saturate the accumulator into the output range.
    always_comb begin
        if (acc > SAT_MAX)      m_data = SAT_MAX[OW-1:0];
        else if (acc < SAT_MIN) m_data = SAT_MIN[OW-1:0];
        else                    m_data = acc[OW-1:0];
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer (TAPS=4, DW=CW=8, OW=16).
module tb_fir_mac_sequencer;

    localparam int TAPS = 4;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int OW   = 16;
    localparam int AW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 coef_wr_en;
    logic [AW-1:0]        coef_wr_addr;
    logic signed [CW-1:0] coef_wr_data;
    logic                 cfg_ready;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [OW-1:0] m_data;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_mac_sequencer #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .cfg_ready    (cfg_ready),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy)
    );

    typedef struct {
        logic signed [7:0]  samp;
        logic signed [15:0] expv;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk({nm, "_ready_timeout"}, 32'(s_ready), 1);
    endtask

    // Called at the negedge right after the accept edge; lat = edges from accept to handshake.
    task automatic wait_out(input string nm, input logic signed [15:0] expv, output int lat);
        int j = 0;
        while (!m_valid && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk({nm, "_valid"}, 32'(m_valid), 1);
        chk({nm, "_data"}, 32'(m_data), 32'(expv));
        lat = j + 1;
    endtask

    task automatic send(input string nm, input logic signed [7:0] d, input logic signed [15:0] expv);
        int lat;
        wait_ready(nm);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        wait_out(nm, expv, lat);
        chk({nm, "_latency"}, lat, 5);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_mvalid_drop"}, 32'(m_valid), 0);
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic signed [7:0] d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = d;
        @(posedge clk);
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        rst          = 1'b1;
        s_valid      = 1'b0;
        s_data       = '0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        m_ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);

        // default coefs (moving sum), then coefs 1..4 impulse, then saturation
        vt[0]  = '{1, 1};      vt[1]  = '{2, 3};      vt[2]  = '{3, 6};      vt[3]  = '{4, 10};
        vt[4]  = '{0, 9};      vt[5]  = '{0, 7};      vt[6]  = '{0, 4};      vt[7]  = '{0, 0};
        vt[8]  = '{1, 1};      vt[9]  = '{0, 2};      vt[10] = '{0, 3};      vt[11] = '{0, 4};
        vt[12] = '{127, 16129}; vt[13] = '{127, 32258}; vt[14] = '{127, 32767}; vt[15] = '{127, 32767};
        vt[16] = '{127, -32768}; vt[17] = '{127, -32768}; vt[18] = '{127, -32768}; vt[19] = '{127, -32768};

        for (int i = 0; i < 20; i++) begin
            if (i == 8) begin
                for (int a = 0; a < 4; a++) write_coef(AW'(a), 8'(a + 1));
            end
            if (i == 12) begin
                for (int a = 0; a < 4; a++) write_coef(AW'(a), 8'sd127);
            end
            if (i == 16) begin
                for (int a = 0; a < 4; a++) write_coef(AW'(a), -8'sd128);
            end
            send($sformatf("vec%0d", i), vt[i].samp, vt[i].expv);
        end

        // Backpressure with s_valid held high throughout
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'sd5;
        @(posedge clk);
        @(negedge clk);
        s_data = 8'sd7;
        wait_out("bp_first", 16'sd5, lat);
        chk("bp_first_latency", lat, 5);
        repeat (6) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(m_valid), 1);
            chk("bp_hold_data", 32'(m_data), 5);
            chk("bp_hold_s_ready", 32'(s_ready), 0);
        end
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_s_ready", 32'(s_ready), 1);
        chk("bp_idle_m_valid", 32'(m_valid), 0);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        chk("bp_second_busy", 32'(busy), 1);
        wait_out("bp_second", 16'sd12, lat);
        @(posedge clk);
        @(negedge clk);
        send("bp_third", 8'sd0, 16'sd12);

        // Coefficient write during MAC must be dropped
        wait_ready("drop");
        s_valid = 1'b1;
        s_data  = 8'sd3;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        chk("drop_cfg_ready", 32'(cfg_ready), 0);
        write_coef(2'd0, 8'sd9);
        wait_out("drop_cur", 16'sd15, lat);
        @(posedge clk);
        @(negedge clk);
        send("drop_next", 8'sd1, 16'sd11);

        // Reset mid-MAC aborts the sample and clears history
        do_reset();
        send("abort_pre", 8'sd5, 16'sd5);
        wait_ready("abort");
        s_valid = 1'b1;
        s_data  = 8'sd5;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        send("after_abort", 8'sd2, 16'sd2);

        // Coefficient write and sample accept in the same IDLE cycle
        wait_ready("simul");
        s_valid      = 1'b1;
        s_data       = 8'sd1;
        coef_wr_en   = 1'b1;
        coef_wr_addr = 2'd0;
        coef_wr_data = 8'sd3;
        @(posedge clk);
        @(negedge clk);
        s_valid    = 1'b0;
        coef_wr_en = 1'b0;
        wait_out("simul", 16'sd5, lat);
        chk("simul_latency", lat, 5);
        @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
